// File: rtl/mole_scheduler_if.sv
// Game-side bundle for mole_scheduler: enable/hit in, lamp, index, strobes
// and counters out.
interface mole_scheduler_if #(
  parameter int NUM_MOLES = 4
);
  logic                 enable;
  logic [NUM_MOLES-1:0] hit;
  logic [NUM_MOLES-1:0] mole_led;
  logic [3:0]           mole_idx;
  logic                 hit_pulse;
  logic                 miss_pulse;
  logic                 wrong_pulse;
  logic [7:0]           score;
  logic [7:0]           misses;

  modport master (
    output enable, hit,
    input  mole_led, mole_idx, hit_pulse, miss_pulse,
    input  wrong_pulse, score, misses
  );

  modport slave (
    input  enable, hit,
    output mole_led, mole_idx, hit_pulse, miss_pulse,
    output wrong_pulse, score, misses
  );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: LFSR-picked mole, gap/hold timing, score keeping.
// Define MOLE_NO_REPEAT_EN to forbid the same mole twice in a row.
module mole_scheduler #(
  parameter int          NUM_MOLES   = 4,
  parameter int          HOLD_CYCLES = 25000000,
  parameter int          GAP_CYCLES  = 5000000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic         clk,
  input logic         reset_n,
  mole_scheduler_if.slave bus
);

  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [31:0] GAP_LD  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] HOLD_LD = 32'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    UP
  } state_e;

  state_e               state_q;
  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_d;
  logic [31:0]          cnt_q;
  logic [NUM_MOLES-1:0] led_q;
  logic [3:0]           idx_q;
  logic                 hit_q;
  logic                 miss_q;
  logic                 wrong_q;
  logic [7:0]           score_q;
  logic [7:0]           misses_q;

  logic [3:0] cand;
  logic       cnt_zero;
  logic       correct;
  logic       wrong;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^
             (lfsr_q[0] ? 16'hB400 : 16'h0000);
    cand   = 4'(lfsr_q[7:0] % 8'(NUM_MOLES));
`ifdef MOLE_NO_REPEAT_EN
    if (cand == idx_q)
      cand = (cand == 4'(NUM_MOLES - 1)) ? 4'd0 : cand + 4'd1;
`endif
  end

  // led_q is one-hot on the live mole, so it doubles as the hit mask
  assign cnt_zero = (cnt_q == 32'd0);
  assign correct  = |(bus.hit & led_q);
  assign wrong    = |(bus.hit & ~led_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      cnt_q    <= '0;
      led_q    <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      wrong_q  <= 1'b0;
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      wrong_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          led_q <= '0;
          if (bus.enable) begin
            state_q  <= GAP;
            cnt_q    <= GAP_LD;
            score_q  <= '0;
            misses_q <= '0;
          end
        end
        GAP: begin
          if (!bus.enable) begin
            state_q <= IDLE;
          end else if (cnt_zero) begin
            state_q <= UP;
            cnt_q   <= HOLD_LD;
            idx_q   <= cand;
            led_q   <= NUM_MOLES'(1) << cand;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        UP: begin
          if (!bus.enable) begin
            state_q <= IDLE;
            led_q   <= '0;
          end else if (correct) begin
            state_q <= GAP;
            cnt_q   <= GAP_LD;
            led_q   <= '0;
            hit_q   <= 1'b1;
            if (score_q != 8'hFF)
              score_q <= score_q + 8'd1;
          end else if (cnt_zero) begin
            state_q <= GAP;
            cnt_q   <= GAP_LD;
            led_q   <= '0;
            miss_q  <= 1'b1;
            if (misses_q != 8'hFF)
              misses_q <= misses_q + 8'd1;
          end else begin
            cnt_q   <= cnt_q - 32'd1;
            wrong_q <= wrong;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mole_led    = led_q;
  assign bus.mole_idx    = idx_q;
  assign bus.hit_pulse   = hit_q;
  assign bus.miss_pulse  = miss_q;
  assign bus.wrong_pulse = wrong_q;
  assign bus.score       = score_q;
  assign bus.misses      = misses_q;

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter NUM_MOLES, default 4: number of moles/LEDs; legal 2..16.
REQ-002 Parameter HOLD_CYCLES, default 25000000: cycles a mole stays lit; legal >= 2.
REQ-003 Parameter GAP_CYCLES, default 5000000: dark cycles between moles; legal >= 1.
REQ-004 Parameter SEED, default 16'hACE1: LFSR reset value; SEED=0 SHALL be replaced by 16'hACE1.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 enable  input  1  game running when high.
REQ-008 hit  input  NUM_MOLES  per-mole button strobes, already debounced and synchronised, one-cycle pulses.
REQ-009 mole_led  output  NUM_MOLES  one-hot active mole, or all zero.
REQ-010 mole_idx  output  4  index of the current or last mole.
REQ-011 hit_pulse  output  1  one-cycle strobe on a correct hit.
REQ-012 miss_pulse  output  1  one-cycle strobe on a timeout.
REQ-013 wrong_pulse  output  1  one-cycle strobe on a wrong-button press.
REQ-014 score  output  8  saturating count of correct hits.
REQ-015 misses  output  8  saturating count of timeouts.

Function
REQ-016 A 16-bit Galois LFSR (taps 0xB400, shift right) SHALL advance every cycle when not in reset, independent of state.
REQ-017 States: IDLE, GAP, UP; all outputs registered.
REQ-018 IDLE: mole_led=0, no strobes; enable=1 -> GAP, down-counter loaded with GAP_CYCLES-1.
REQ-019 GAP: mole_led=0; counter decrements each cycle; on counter==0 -> UP next cycle, counter loaded with HOLD_CYCLES-1.
REQ-020 On GAP->UP: candidate = lfsr[7:0] mod NUM_MOLES, sampled on the transition cycle; mole_idx=candidate, mole_led=1<<candidate in the first UP cycle.
REQ-021 UP, hit[mole_idx]=1: hit_pulse=1 next cycle, score+1 (saturating at 255), mole_led=0, -> GAP.
REQ-022 UP, hit[mole_idx]=0 and any other hit bit=1: wrong_pulse=1 next cycle; state and timer unchanged.
REQ-023 UP, counter==0 with no correct hit: miss_pulse=1 next cycle, misses+1 (saturating at 255), mole_led=0, -> GAP.
REQ-024 A correct hit in the same cycle as timeout SHALL count as a hit only; correct plus wrong bits in the same cycle SHALL count as a hit only.
REQ-025 hit input in IDLE or GAP SHALL be ignored, with no strobe.
REQ-026 enable=0 in any state -> IDLE next cycle, mole_led=0, no strobe; score and misses held.
REQ-027 IDLE->GAP on re-enable SHALL clear score and misses.
REQ-028 At most one of hit_pulse, miss_pulse, wrong_pulse SHALL be high in any cycle.

Reset
REQ-029 reset_n=0 at a clock edge: state=IDLE, lfsr=SEED (or 16'hACE1), counter=0, mole_led=0, mole_idx=0, all strobes=0, score=0, misses=0.
REQ-030 Reset mid-UP or mid-GAP SHALL abort with no strobe emitted.

Configuration
REQ-031 Macro MOLE_NO_REPEAT_EN defined: if candidate equals previous mole_idx, mole_idx SHALL be (candidate+1) mod NUM_MOLES, so consecutive moles always differ.
REQ-032 Macro MOLE_NO_REPEAT_EN undefined: candidate used unchanged; repeats permitted.

Verification (NUM_MOLES=4, HOLD_CYCLES=8, GAP_CYCLES=3)
REQ-033 reset_n=0 for 2 cycles, then enable=1 -> mole_led=0 for 3 cycles, then a one-hot mole_led matching lfsr[7:0] mod 4 at the transition, held for 8 cycles, then miss_pulse=1 and misses=1.
REQ-034 Mole at idx 2; pulse hit=4'b0100 on UP cycle 3 -> hit_pulse next cycle, score=1, mole_led=0, next mole after 3 dark cycles.
REQ-035 Mole at idx 2; hit=4'b0001 -> wrong_pulse=1, mole_led stays 4'b0100, miss_pulse at original timeout.
REQ-036 Correct hit on final UP cycle (counter==0) -> hit_pulse only, misses unchanged; 260 forced hits -> score stays 255.
REQ-037 enable=0 mid-UP -> IDLE, mole_led=0, no strobes; re-enable -> score=0, misses=0.
REQ-038 With MOLE_NO_REPEAT_EN over 1000 moles: no two consecutive mole_idx equal, all 4 indices appear; without the macro, at least one repeat appears with SEED=16'hACE1.
